// File: rtl/md_lohi_unit.sv
// md_lohi_unit: iterative multiply/divide engine with architectural Hi/Lo registers.
// Define MD_FAST_MULT_EN to replace the iterative multiply with a single-cycle multiplier.
module md_lohi_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             md_is_mult,
  input  logic             md_is_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             lhr_ren,
  input  logic             lhr_is_hi,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mult_q, mult_d, neg_q, neg_d, negr_q, negr_d, done_q, done_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, hacc_q, hacc_d, lacc_q, lacc_d, hi_q, hi_d, lo_q, lo_d;
  logic sa, sb, dz, ge;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0] madd, dsh, dsub;
`ifdef MD_FAST_MULT_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{sa}}, op_a} * {{WIDTH{sb}}, op_b};
`endif
  assign sa    = ~md_is_unsigned & op_a[WIDTH-1];
  assign sb    = ~md_is_unsigned & op_b[WIDTH-1];
  assign abs_a = sa ? -op_a : op_a;
  assign abs_b = sb ? -op_b : op_b;
  assign dz    = ~md_is_mult & (op_b == '0);
  // opnd_q holds the multiplicand or the divisor; lacc_q starts as multiplier or dividend
  assign madd  = {1'b0, hacc_q} + (lacc_q[0] ? {1'b0, opnd_q} : '0);
  assign dsh   = {hacc_q, lacc_q[WIDTH-1]};
  assign dsub  = dsh - {1'b0, opnd_q};
  assign ge    = ~dsub[WIDTH];
  assign rdata = lhr_ren ? (lhr_is_hi ? hi_q : lo_q) : '0;
  assign busy  = state_q != IDLE;
  assign done  = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mult_d  = mult_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    opnd_d  = opnd_q;
    hacc_d  = hacc_q;
    lacc_d  = lacc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        cnt_d   = '0;
        mult_d  = md_is_mult;
        neg_d   = sa ^ sb;
        negr_d  = sa;
        opnd_d  = md_is_mult ? abs_a : abs_b;
        hacc_d  = '0;
        lacc_d  = md_is_mult ? abs_b : abs_a;
        if (dz) begin
          state_d = FIX;
          hacc_d  = op_a;
          lacc_d  = '1;
          neg_d   = 1'b0;
          negr_d  = 1'b0;
        end
`ifdef MD_FAST_MULT_EN
        if (md_is_mult) begin
          state_d          = FIX;
          {hacc_d, lacc_d} = prod;
          neg_d            = 1'b0;
        end
`else
`endif
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (mult_q) {hacc_d, lacc_d} = {madd, lacc_q[WIDTH-1:1]};
        else begin
          hacc_d = ge ? dsub[WIDTH-1:0] : dsh[WIDTH-1:0];
          lacc_d = {lacc_q[WIDTH-2:0], ge};
        end
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (mult_q) {hi_d, lo_d} = neg_q ? -{hacc_q, lacc_q} : {hacc_q, lacc_q};
        else begin
          lo_d = neg_q ? -lacc_q : lacc_q;
          hi_d = negr_q ? -hacc_q : hacc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mult_q  <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      opnd_q  <= '0;
      hacc_q  <= '0;
      lacc_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mult_q  <= mult_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      opnd_q  <= opnd_d;
      hacc_q  <= hacc_d;
      lacc_q  <= lacc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: doc/md_lohi_unit.md
# md_lohi_unit

Multi-cycle multiply/divide engine with architectural Hi/Lo registers, sitting directly downstream of the control unit. It consumes the decoded `md_is_mult`, `md_is_unsigned`, `lhr_wen`, `lhr_ren` and `lhr_is_hi` controls together with the two register-file read operands. It executes MULT/MULTU/DIV/DIVU iteratively, one result bit per cycle, and serves MFHI/MFLO reads. It raises `busy` so the hazard/stall logic can hold the pipeline while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand width; Hi and Lo are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch an operation; driven from control unit `lhr_wen`, qualified by instruction valid.
- `md_is_mult`  in  1  1 = multiply, 0 = divide; sampled with `start`.
- `md_is_unsigned`  in  1  1 = MULTU/DIVU, 0 = signed; sampled with `start`.
- `op_a`  in  WIDTH  rs operand (multiplicand / dividend).
- `op_b`  in  WIDTH  rt operand (multiplier / divisor).
- `lhr_ren`  in  1  MFHI/MFLO read enable.
- `lhr_is_hi`  in  1  1 = read Hi, 0 = read Lo.
- `rdata`  out  WIDTH  read data; combinational from Hi/Lo, 0 when `lhr_ren`=0.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; Hi/Lo are updated.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE: `start`=1 latches the operands and the mode, and moves to CALC with iteration counter = 0.
  - Signed mode stores |op_a| and |op_b|, plus `neg_q` = sign(a)^sign(b) and `neg_r` = sign(a).
- CALC runs 32 iterations, counter 0..31, then moves to FIX.
  - Multiply: shift-add over a 64-bit accumulator {hi_acc, lo_acc}.
  - Divide: restoring division; quotient goes to lo_acc, remainder to hi_acc.
- FIX applies the sign correction, writes Hi/Lo, and returns to IDLE.
  - Multiply: 64-bit negate if `neg_q`.
  - Divide: quotient negated if `neg_q`, remainder negated if `neg_r`.
- Divide by zero (`op_b`=0, divide mode) is detected at `start`:
  - CALC is skipped and the FSM goes straight to FIX.
  - Result: Lo = all ones, Hi = op_a unmodified; no sign fix.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0. This falls out of two's-complement wrap and is not trapped.
- `start` while `busy`=1 is ignored: no relaunch, no error.
- The Hi/Lo registers change only in FIX.
- MFHI/MFLO issued while `busy` returns the previous Hi/Lo. Stalling on `busy` is the hazard unit's job.
- The accumulators are internal. Hi/Lo never show partial results.

## Timing
- Reset values: all outputs 0 (`rdata` 0, `busy` 0, `done` 0); Hi = Lo = 0; FSM in IDLE; counter 0.
- Reset asserted mid-operation aborts the operation immediately. Hi/Lo become 0 and no `done` is produced.
- Launch: `start` is sampled at edge T0.
- `busy` is high from the cycle after T0 through the FIX cycle inclusive, and low in IDLE.
- Normal op: 32 CALC cycles + 1 FIX cycle gives `busy` high for 33 cycles. Hi/Lo are written at the end of FIX, i.e. at edge T0+33.
- `done` is registered. It is high for exactly one cycle, the cycle after the Hi/Lo write, coincident with IDLE and `busy`=0.
- A new `start` is accepted in the same cycle that `done` is high.
- Divide by zero: `busy` is high for 1 cycle (FIX only); `done` follows one cycle later.
- `rdata` has zero latency and reflects the Hi/Lo register contents in the same cycle as `lhr_ren`.

## Configuration
- `MD_FAST_MULT_EN` defined:
  - Multiply skips CALC. The product comes from a single-cycle WIDTH×WIDTH multiplier (signed or unsigned per mode) and is written in FIX.
  - `busy` is high for 1 cycle and `done` follows one cycle later.
  - Divide timing is unchanged.
- `MD_FAST_MULT_EN` undefined: multiply is iterative, 33 busy cycles, as above.
- Results are bit-identical in both builds.

## Test plan
- Reset, then MFLO and MFHI with `lhr_ren`=1 -> `rdata`=0 both; `busy`=0, `done`=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 busy cycles, Hi=0xFFFFFFFE, Lo=0x00000001; `done` one-cycle pulse; MFHI/MFLO read those values.
- Signed cases:
  - MULT -7 × 3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
  - DIV -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
  - DIVU 100 / 7 -> Lo=14, Hi=2.
- Division edge cases:
  - DIV 5 / 0 -> `busy` 1 cycle, Lo=0xFFFFFFFF, Hi=5.
  - DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Busy-window behaviour:
  - Second `start` at busy cycle 10 -> ignored; the first result completes at T0+33.
  - MFLO at busy cycle 5 -> old Lo.
- `rst_n` low at busy cycle 20 -> `busy` 0 immediately, Hi/Lo=0, no `done`.
  - A following MULTU 3×4 -> Lo=12, Hi=0.
  - With `MD_FAST_MULT_EN`, that MULTU shows `busy` for 1 cycle.
